lcd_bus_arbiter: RTL and testbench
==================================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter T_SU, default 2, meaning: clk cycles rs/dat are stable before en rises (minimum 1).
REQ-002 Parameter T_EN, default 12, meaning: clk cycles en is held high (minimum 1).
REQ-003 Parameter T_HOLD, default 2, meaning: clk cycles rs/dat are held after en falls (minimum 1).
REQ-004 Parameter T_SHORT, default 2000, meaning: execution wait for ordinary commands and data (40 us at 50 MHz).
REQ-005 Parameter T_LONG, default 82000, meaning: execution wait for clear/home commands (1.64 ms at 50 MHz); wait counter width SHALL hold max(T_SHORT, T_LONG).
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 req0 / req1  input  1  requester 0 (init/command source) / requester 1 (text source) transfer request.
REQ-009 rs0 / rs1  input  1  requested register select (0 command, 1 data).
REQ-010 dat0 / dat1  input  8  requested byte.
REQ-011 ack0 / ack1  output  1  one-cycle grant pulse; byte accepted.
REQ-012 rs  output  1  LCD register select.
REQ-013 rw  output  1  LCD read/write; constant 0 (write only).
REQ-014 en  output  1  LCD enable strobe.
REQ-015 dat  output  8  LCD data bus.
REQ-016 busy  output  1  high while a transfer or its execution wait is in progress.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, PULSE, HOLD, WAIT; one down-counter reloaded on every state entry.
REQ-018 IDLE: if no req, stay; if exactly one req, grant it; if both, grant the requester not granted last (round-robin); last-grant pointer resets to requester 1, so requester 0 wins the first contention.
REQ-019 Grant cycle: the edge leaving IDLE SHALL latch the winner's rs/dat into rs/dat, pulse its ack for exactly that one cycle, set busy, enter SETUP.
REQ-020 Requester SHALL hold req/rs/dat stable until ack; req still high in the cycle after ack is a new request.
REQ-021 SETUP lasts T_SU cycles with en=0; PULSE lasts T_EN cycles with en=1; HOLD lasts T_HOLD cycles with en=0; rs/dat SHALL not change from grant through end of HOLD.
REQ-022 WAIT lasts T_LONG cycles when latched rs=0 and dat is 0x01, 0x02 or 0x03; otherwise T_SHORT cycles.
REQ-023 Data writes (rs=1) SHALL always use T_SHORT regardless of byte value.
REQ-024 Leaving WAIT returns to IDLE and clears busy; arbitration in that same IDLE cycle; a pending request is granted in the first IDLE cycle (one-cycle IDLE gap between transfers).
REQ-025 Total busy duration per transfer = T_SU + T_EN + T_HOLD + wait cycles; en rises exactly T_SU cycles after the grant edge.
REQ-026 Requests arriving while busy SHALL be ignored (no ack) until IDLE; they are not lost if held.
REQ-027 In IDLE rs/dat keep the last latched values; en=0.
REQ-028 en SHALL be driven from a register (glitch-free), never from combinational logic.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, en=0, ack0=ack1=0, busy=0, rs=0, dat=0x00, rw=0, last grant = requester 1, counter 0.
REQ-030 Reset mid-transfer SHALL abort the transfer with no further en pulse; after rst_n rises, operation restarts from IDLE with no memory of the aborted transfer.

Verification (T_SU=2, T_EN=4, T_HOLD=2, T_SHORT=10, T_LONG=50)
REQ-031 req0, rs0=0, dat0=0x38 -> one ack0 pulse, rs=0, dat=0x38, en high 4 cycles starting 2 cycles after grant, busy high 18 cycles.
REQ-032 req0, rs0=0, dat0=0x01 -> long wait, busy high 58 cycles; then rs0=1, dat0=0x01 -> busy high 18 cycles.
REQ-033 req0 and req1 held together from reset -> grants alternate 0,1,0,1; each ack one cycle; no overlapping en pulses.
REQ-034 req1 held with rs1=1, dat1=0x4B ("K") -> back-to-back transfers, one ack1 per transfer, one IDLE cycle between busy periods.
REQ-035 rst_n low during PULSE -> en falls without waiting for a clock edge, busy=0; after release, new req0 0x0C completes normally in 18 cycles.
REQ-036 req1 asserted mid-transfer of requester 0 -> no ack1 until IDLE; ack1 in the first IDLE cycle, dat unchanged until then.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Two-requester arbiter for an HD44780-style LCD write bus.
// A round-robin grant latches one byte, which is then played out as a
// setup / enable-pulse / hold sequence followed by the controller's
// execution wait. A clear or home command gets the long wait. Every
// other command or data byte gets the short wait.
module lcd_bus_arbiter #(
    parameter int T_SU    = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_SHORT = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] dat0,
    input  logic [7:0] dat1,
    output logic       ack0,
    output logic       ack1,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] dat,
    output logic       busy
);

    localparam int T_MAX = (T_LONG > T_SHORT) ? T_LONG : T_SHORT;
    localparam int CW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rs_q, rs_d;
    logic [7:0]      dat_q, dat_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            last_q, last_d;   // index of the requester granted last

    logic            gnt0, gnt1;
    logic            long_wait;

    // On contention, the requester that was not served last wins.
    assign gnt0 = req0 && (!req1 || last_q);
    assign gnt1 = req1 && (!req0 || !last_q);

    // Only clear-display (0x01) and return-home (0x02/0x03) commands need the long wait.
    assign long_wait = !rs_q && ((dat_q == 8'h01) || (dat_q == 8'h02) || (dat_q == 8'h03));

    // Next-state, counter reload and latch decisions for the transfer sequencer.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        dat_d   = dat_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt0) begin
                    rs_d    = rs0;
                    dat_d   = dat0;
                    ack0_d  = 1'b1;
                    last_d  = 1'b0;
                    state_d = SETUP;
                    cnt_d   = CW'(T_SU - 1);
                end else if (gnt1) begin
                    rs_d    = rs1;
                    dat_d   = dat1;
                    ack1_d  = 1'b1;
                    last_d  = 1'b1;
                    state_d = SETUP;
                    cnt_d   = CW'(T_SU - 1);
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CW'(T_EN - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = WAIT;
                    cnt_d   = long_wait ? CW'(T_LONG - 1) : CW'(T_SHORT - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that en and busy come straight off flops.
    always_comb begin
        en_d   = (state_d == PULSE);
        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset aborts any transfer, and en drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            dat_q   <= 8'h00;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            dat_q   <= dat_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            last_q  <= last_d;
        end
    end

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign rs   = rs_q;
    assign rw   = 1'b0;
    assign en   = en_q;
    assign dat  = dat_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter with short timing parameters.
// A transfer-level reference model tracks the cycles left in the current
// transfer and the time since its grant. Directed scenarios are followed
// by randomized requester traffic.
module tb_lcd_bus_arbiter;

    localparam int T_SU    = 2;
    localparam int T_EN    = 4;
    localparam int T_HOLD  = 2;
    localparam int T_SHORT = 10;
    localparam int T_LONG  = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       rs0 = 1'b0, rs1 = 1'b0;
    logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
    logic       ack0, ack1, rs, rw, en, busy;
    logic [7:0] dat;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int         m_rem;    // busy cycles still to come, including the current one
    int         m_el;     // cycles since the grant edge
    int         m_last;
    logic       m_rs;
    logic [7:0] m_dat;
    logic       m_ack0, m_ack1;

    bit auto_drop = 1'b1;

    lcd_bus_arbiter #(
        .T_SU(T_SU), .T_EN(T_EN), .T_HOLD(T_HOLD), .T_SHORT(T_SHORT), .T_LONG(T_LONG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .rs0(rs0), .rs1(rs1), .dat0(dat0), .dat1(dat1),
        .ack0(ack0), .ack1(ack1), .rs(rs), .rw(rw), .en(en), .dat(dat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_len(input logic r, input logic [7:0] d);
        return (!r && d >= 8'h01 && d <= 8'h03) ? T_LONG : T_SHORT;
    endfunction

    task automatic model_reset();
        m_rem = 0; m_el = 0; m_last = 1; m_rs = 1'b0; m_dat = 8'h00;
        m_ack0 = 1'b0; m_ack1 = 1'b0;
    endtask

    // Advances the model by one clock edge, using the inputs as they stood before the edge.
    task automatic model_step();
        int w;
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        if (m_rem == 0) begin
            w = -1;
            if (req0 && req1) w = (m_last == 1) ? 0 : 1;
            else if (req0)    w = 0;
            else if (req1)    w = 1;
            if (w == 0) begin m_rs = rs0; m_dat = dat0; m_ack0 = 1'b1; end
            if (w == 1) begin m_rs = rs1; m_dat = dat1; m_ack1 = 1'b1; end
            if (w >= 0) begin
                m_last = w;
                m_el = 0;
                m_rem = T_SU + T_EN + T_HOLD + wait_len(m_rs, m_dat);
            end
        end else begin
            m_rem--;
            m_el++;
        end
    endtask

    task automatic check_outputs();
        logic exp_en;
        exp_en = (m_rem > 0) && (m_el >= T_SU) && (m_el < T_SU + T_EN);
        check("ack0", ack0, m_ack0);
        check("ack1", ack1, m_ack1);
        check("busy", busy, m_rem > 0);
        check("en", en, exp_en);
        check("rs", rs, m_rs);
        check("dat", dat, m_dat);
        check("rw", rw, 1'b0);
    endtask

    // One clock: edge, model update, sample 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (auto_drop) begin
            if (m_ack0) req0 = 1'b0;
            if (m_ack1) req1 = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ack", {ack0, ack1}, 2'b00);
        check("rst_dat", {rs, dat}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic measure(input int ncyc, output int busy_len, output int en_off,
                           output int en_len, output int acks);
        int ack_idx, en_idx;
        ack_idx = -1; en_idx = -1;
        busy_len = 0; en_len = 0; acks = 0;
        for (int i = 0; i < ncyc; i++) begin
            cycle();
            if (busy) busy_len++;
            if (en) begin en_len++; if (en_idx < 0) en_idx = i; end
            if (ack0 || ack1) begin acks++; if (ack_idx < 0) ack_idx = i; end
        end
        en_off = en_idx - ack_idx;
    endtask

    task automatic new_req(input int which);
        logic       r;
        logic [7:0] d;
        r = 1'($urandom_range(1, 0));
        d = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(3, 0)) : 8'($urandom_range(255, 0));
        if (which == 0) begin req0 = 1'b1; rs0 = r; dat0 = d; end
        else            begin req1 = 1'b1; rs1 = r; dat1 = d; end
    endtask

    initial begin
        int bl, eo, el, ac;
        int grants[$];
        int idle_run, gaps, idle_idx, ack1_idx, k;
        logic prev_busy;

        // Reset values
        apply_reset();

        // Ordinary command 0x38
        req0 = 1'b1; rs0 = 1'b0; dat0 = 8'h38;
        measure(30, bl, eo, el, ac);
        check("t1_busy_len", bl, 18);
        check("t1_en_offset", eo, 2);
        check("t1_en_len", el, 4);
        check("t1_acks", ac, 1);
        check("t1_dat_idle", {rs, dat}, {1'b0, 8'h38});

        // Clear command takes the long wait. The same byte as data takes the short wait.
        req0 = 1'b1; rs0 = 1'b0; dat0 = 8'h01;
        measure(70, bl, eo, el, ac);
        check("t2_clear_busy_len", bl, 58);
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h01;
        measure(30, bl, eo, el, ac);
        check("t2_data_busy_len", bl, 18);

        // Contention from reset: grants alternate, requester 0 first
        auto_drop = 1'b0;
        rst_n = 1'b0;
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h41;
        req1 = 1'b1; rs1 = 1'b1; dat1 = 8'h42;
        apply_reset();
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (ack0) grants.push_back(0);
            if (ack1) grants.push_back(1);
        end
        check("t3_grant_count", grants.size(), 5);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("t3_grant%0d", i), grants[i], i % 2);

        // Requester 1 holds a data request: back-to-back with one idle cycle between
        req0 = 1'b0;
        req1 = 1'b1; rs1 = 1'b1; dat1 = 8'h4B;
        idle_run = 0; gaps = 0; prev_busy = busy;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (!busy) idle_run++;
            if (busy && !prev_busy) begin
                if (gaps > 0 || i > 1) begin
                    check("t4_idle_gap", idle_run, 1);
                    gaps++;
                end
                idle_run = 0;
            end
            prev_busy = busy;
        end
        check("t4_gaps_seen", gaps >= 3, 1'b1);
        req1 = 1'b0;
        auto_drop = 1'b1;
        repeat (20) cycle();

        // Reset during the enable pulse
        req0 = 1'b1; rs0 = 1'b0; dat0 = 8'h0C;
        k = 0;
        while (k < 20 && !en) begin cycle(); k++; end
        check("t5_en_seen", en, 1'b1);
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_en_async", en, 1'b0);
        check("t5_busy_async", busy, 1'b0);
        check("t5_dat_async", {rs, dat}, 9'h000);
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; rs0 = 1'b0; dat0 = 8'h0C;
        measure(30, bl, eo, el, ac);
        check("t5_busy_len", bl, 18);
        check("t5_en_len", el, 4);

        // Requester 1 arrives mid-transfer: served in the first idle cycle
        req0 = 1'b1; rs0 = 1'b0; dat0 = 8'h38;
        idle_idx = -1; ack1_idx = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (i == 5) begin req1 = 1'b1; rs1 = 1'b1; dat1 = 8'h55; end
            if (i > 0 && !busy && idle_idx < 0) idle_idx = i;
            if (ack1 && ack1_idx < 0) ack1_idx = i;
        end
        check("t6_idle_idx", idle_idx, 18);
        check("t6_ack1_idx", ack1_idx, 19);
        repeat (20) cycle();

        // Randomized traffic from both requesters
        auto_drop = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            cycle();
            if (req0) begin
                if (m_ack0) begin
                    if ($urandom_range(1, 0) == 1) new_req(0); else req0 = 1'b0;
                end
            end else if ($urandom_range(3, 0) == 0) new_req(0);
            if (req1) begin
                if (m_ack1) begin
                    if ($urandom_range(1, 0) == 1) new_req(1); else req1 = 1'b0;
                end
            end else if ($urandom_range(3, 0) == 0) new_req(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
